// File: rtl/app_mul_pipe.sv
// Three-stage pipelined Mitchell logarithmic approximate multiplier with valid/ready handshake.
// Define APP_MUL_CORRECTION_EN to add the fraction error-correction constant in stage 2.
module app_mul_pipe #(
  parameter int WIDTH     = 16,
  parameter int TAG_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_signed,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int F  = WIDTH - 1;
  localparam int KW = $clog2(WIDTH);
  localparam int EW = $clog2(2 * WIDTH);
  localparam int PW = 2 * WIDTH + F;

  function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] x);
    lead_one = '0;
    for (int i = 0; i < WIDTH; i++)
      if (x[i]) lead_one = KW'(i);
  endfunction

  // Shift the leading one up to the MSB; the bits beneath it form the fraction.
  function automatic logic [F-1:0] frac_of(input logic [WIDTH-1:0] x, input logic [KW-1:0] k);
    frac_of = F'(x << (KW'(F) - k));
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 combinational
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg0, zero0;

  always_comb begin
    mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    neg0  = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    zero0 = (mag_a == '0) || (mag_b == '0);
  end

  logic                 v1, neg1, zero1;
  logic [KW-1:0]        k_a1, k_b1;
  logic [F-1:0]         f_a1, f_b1;
  logic [TAG_WIDTH-1:0] tag1;

  // Stage 2 combinational
  logic [F:0]    s_sum;
  logic          carry;
  logic [F-1:0]  frac;
  logic [EW-1:0] e_next;

`ifdef APP_MUL_CORRECTION_EN
  localparam logic [F-1:0] CORR_C0 = F'((64'd5 << F) >> 6);
  localparam logic [F-1:0] CORR_C1 = F'((64'd5 << F) >> 7);
  logic [F:0] corr_sum;
`endif

  always_comb begin
    s_sum  = {1'b0, f_a1} + {1'b0, f_b1};
    carry  = s_sum[F];
    e_next = EW'(k_a1) + EW'(k_b1) + EW'(carry);
`ifdef APP_MUL_CORRECTION_EN
    corr_sum = {1'b0, s_sum[F-1:0]} + {1'b0, (carry ? CORR_C1 : CORR_C0)};
    frac     = corr_sum[F] ? '1 : corr_sum[F-1:0];
`else
    frac     = s_sum[F-1:0];
`endif
  end

  logic                 v2, neg2, zero2;
  logic [F:0]           m2;
  logic [EW-1:0]        e2;
  logic [TAG_WIDTH-1:0] tag2;

  // Stage 3 combinational
  logic [PW-1:0]      wide;
  logic [2*WIDTH-1:0] mag_p, prod;

  always_comb begin
    wide  = PW'(m2) << e2;
    mag_p = (2*WIDTH)'(wide >> F);
    if (zero2)     prod = '0;
    else if (neg2) prod = -mag_p;
    else           prod = mag_p;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (adv) begin
      v1    <= in_valid;
      k_a1  <= lead_one(mag_a);
      k_b1  <= lead_one(mag_b);
      f_a1  <= frac_of(mag_a, lead_one(mag_a));
      f_b1  <= frac_of(mag_b, lead_one(mag_b));
      neg1  <= neg0;
      zero1 <= zero0;
      tag1  <= in_tag;

      v2    <= v1;
      m2    <= {1'b1, frac};
      e2    <= e_next;
      neg2  <= neg1;
      zero2 <= zero1;
      tag2  <= tag1;

      out_valid <= v2;
      if (v2) begin
        out_product <= prod;
        out_tag     <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_app_mul_pipe.sv
// Directed-vector bench for app_mul_pipe: hand-computed products, latency, stall and reset flush.
module tb_app_mul_pipe;
  localparam int W  = 16;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid;
  logic [2*W-1:0] out_product;
  logic [TW-1:0] out_tag;

  app_mul_pipe #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

`ifdef APP_MUL_CORRECTION_EN
  localparam logic [31:0] E2 = 32'd17, E3 = 32'hFFFF_FFEF, E4 = 32'hFFFF_7600,
                          E5 = 32'h0001_1400, E6 = 32'hFFFF_0000, E9 = 32'd29,
                          E10 = 32'h0003_FFFC;
`else
  localparam logic [31:0] E2 = 32'd16, E3 = 32'hFFFF_FFF0, E4 = 32'hFFFF_8000,
                          E5 = 32'h0001_0000, E6 = 32'hFFFE_0000, E9 = 32'd28,
                          E10 = 32'h0003_FFF0;
`endif

  typedef struct {
    logic [31:0]   p;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t          q[$];
  exp_t          e_pop;
  int            n_vec = 0, n_err = 0, cyc = 0, n_out = 0;
  bit            chk_lat = 1'b0, prev_stall = 1'b0;
  logic [31:0]   cur_exp = '0;
  logic [31:0]   prev_p;
  logic [TW-1:0] prev_t;

  logic          vsg[11];
  logic [W-1:0]  va[11], vb[11];
  logic [31:0]   vexp[11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic send(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t, input logic [31:0] ex);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_signed = sg;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    cur_exp   = ex;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 64'(q.size()), 64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_product", 64'(out_product), 64'(prev_p));
        chk("stall_tag", 64'(out_tag), 64'(prev_t));
      end
      if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stale_result", 64'(out_valid), 64'd0);
        end else begin
          e_pop = q.pop_front();
          chk("product", 64'(out_product), 64'(e_pop.p));
          chk("tag", 64'(out_tag), 64'(e_pop.tag));
          if (chk_lat) chk("latency", 64'(cyc - e_pop.acc), 64'd3);
          n_out++;
        end
      end
      if (in_valid && in_ready) q.push_back('{p: cur_exp, tag: in_tag, acc: cyc});
      prev_stall = out_valid && !out_ready;
      prev_p     = out_product;
      prev_t     = out_tag;
    end
  end

  initial begin
    vsg[0]  = 1'b0; va[0]  = 16'h0003; vb[0]  = 16'h0003; vexp[0]  = 32'd8;
    vsg[1]  = 1'b0; va[1]  = 16'h0000; vb[1]  = 16'hFFFF; vexp[1]  = 32'd0;
    vsg[2]  = 1'b0; va[2]  = 16'h0004; vb[2]  = 16'h0004; vexp[2]  = E2;
    vsg[3]  = 1'b1; va[3]  = 16'hFFFC; vb[3]  = 16'h0004; vexp[3]  = E3;
    vsg[4]  = 1'b1; va[4]  = 16'h8000; vb[4]  = 16'h0001; vexp[4]  = E4;
    vsg[5]  = 1'b0; va[5]  = 16'h8000; vb[5]  = 16'h0002; vexp[5]  = E5;
    vsg[6]  = 1'b0; va[6]  = 16'hFFFF; vb[6]  = 16'hFFFF; vexp[6]  = E6;
    vsg[7]  = 1'b1; va[7]  = 16'hFFFF; vb[7]  = 16'h0003; vexp[7]  = 32'hFFFF_FFFD;
    vsg[8]  = 1'b1; va[8]  = 16'h8000; vb[8]  = 16'h0000; vexp[8]  = 32'd0;
    vsg[9]  = 1'b0; va[9]  = 16'h0005; vb[9]  = 16'h0006; vexp[9]  = E9;
    vsg[10] = 1'b0; va[10] = 16'hFFFC; vb[10] = 16'h0004; vexp[10] = E10;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_product", 64'(out_product), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // back-to-back stream, no backpressure
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) send(vsg[i], va[i], vb[i], TW'(i), vexp[i]);
    drain("drain_stream");
    chk("stream_count", 64'(n_out), 64'd8);
    chk_lat = 1'b0;

    // backpressure for 5 cycles mid-stream
    n_out = 0;
    fork
      begin
        for (int i = 8; i < 11; i++) send(vsg[i], va[i], vb[i], TW'(i), vexp[i]);
        for (int i = 0; i < 5; i++) send(vsg[i], va[i], vb[i], TW'(16 + i), vexp[i]);
      end
      begin
        for (int i = 0; i < 50 && !out_valid; i++) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    chk("stall_count", 64'(n_out), 64'd8);

    // reset with three ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vsg[i], va[i], vb[i], TW'(40 + i), vexp[i]);
    chk("filled_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_product", 64'(out_product), 64'd0);
    reset = 1'b0;
    q.delete();
    out_ready = 1'b1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
